player_edge_detector: RTL and testbench

- Sits directly upstream of the player motion block. Watches the VGA raster and classifies pixels where the player sprite overlaps solid level tiles by which sprite edge they fall on.
- Integrates those pixels over one frame, adds screen-border contacts, and reports a per-frame collision pulse plus a 4-bit HitEdgeCode.
- The motion block uses this report to stop, land, or block movement.

---
 rtl/player_pkg.sv | 27 ++
 rtl/edge_band_classifier.sv | 48 ++++
 rtl/player_edge_detector.sv | 164 ++++++++++++++++
 tb/tb_player_edge_detector.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/player_pkg.sv
// ---------------------------------------------------------------------------
// player_pkg
// Definitions shared by the player edge detector and the player motion block:
// edge bit positions within a HitEdgeCode, the edge-code type, the offset
// type used for sprite-relative coordinates, and the detector FSM states.
// ---------------------------------------------------------------------------
package player_pkg;

  // Bit positions inside a HitEdgeCode (the motion block decodes the same way).
  localparam int EDGE_LEFT   = 3;
  localparam int EDGE_TOP    = 2;
  localparam int EDGE_RIGHT  = 1;
  localparam int EDGE_BOTTOM = 0;

  typedef logic [3:0] edge_code_t;

  // Sprite-relative pixel offset (raster minus sprite top-left), signed.
  localparam int OFF_W = 12;
  typedef logic signed [OFF_W-1:0] off_t;

  typedef enum logic [1:0] {
    ST_ACCUM  = 2'd0,
    ST_SNAP   = 2'd1,
    ST_REPORT = 2'd2
  } det_state_t;

endpackage

// File: rtl/edge_band_classifier.sv
// ---------------------------------------------------------------------------
// edge_band_classifier
// Purely combinational. Maps a sprite-relative offset to the set of sprite
// edge bands it lies in, and flags whether the offset is inside the sprite.
//   offx_i, offy_i : sprite-relative offset (signed)
//   band_o         : edge mask, bit order per player_pkg EDGE_* constants
//   valid_o        : offset lies inside the SPRITE_W x SPRITE_H box
// Top/bottom bands span the full width; left/right bands exclude the rows
// already owned by top/bottom, so a corner pixel only ever counts as
// top or bottom.
// ---------------------------------------------------------------------------
module edge_band_classifier
  import player_pkg::*;
#(
  parameter int SPRITE_W = 32,
  parameter int SPRITE_H = 32,
  parameter int EDGE_W   = 4
) (
  input  off_t       offx_i,
  input  off_t       offy_i,
  output edge_code_t band_o,
  output logic       valid_o
);

  localparam off_t SW = off_t'(SPRITE_W);
  localparam off_t SH = off_t'(SPRITE_H);
  localparam off_t EW = off_t'(EDGE_W);

  logic in_x;
  logic in_y;
  logic side_y;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path can leave it unassigned and infer a latch.
    band_o  = '0;
    in_x    = (offx_i >= off_t'(0)) && (offx_i < SW);
    in_y    = (offy_i >= off_t'(0)) && (offy_i < SH);
    valid_o = in_x && in_y;
    side_y  = (offy_i >= EW) && (offy_i < (SH - EW));

    band_o[EDGE_TOP]    = (offy_i < EW);
    band_o[EDGE_BOTTOM] = (offy_i >= (SH - EW));
    band_o[EDGE_LEFT]   = side_y && (offx_i < EW);
    band_o[EDGE_RIGHT]  = side_y && (offx_i >= (SW - EW));
  end

endmodule

// File: rtl/player_edge_detector.sv
// ---------------------------------------------------------------------------
// player_edge_detector
// Watches the raster, counts player/brick overlap pixels per sprite edge over
// one frame, folds in screen-border contact, and reports once per frame.
//   clk, resetN   : clock, asynchronous active-low reset
//   startOfFrame  : one-cycle frame-start pulse
//   pixelX/Y      : current raster position (unsigned)
//   playerDR      : player sprite draws this pixel
//   brickDR       : solid tile draws this pixel
//   topLeftX/Y    : player top-left corner (signed)
//   collision     : one-cycle pulse two cycles after startOfFrame if any edge hit
//   HitEdgeCode   : {left, top, right, bottom}, updated once per frame
//   overlapCount  : total overlap pixels of the previous frame (saturating)
// ---------------------------------------------------------------------------
module player_edge_detector
  import player_pkg::*;
#(
  parameter int SPRITE_W = 32,
  parameter int SPRITE_H = 32,
  parameter int EDGE_W   = 4,
  parameter int MIN_HITS = 3,
  parameter int CNT_W    = 8,
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480
) (
  input  logic              clk,
  input  logic              resetN,
  input  logic              startOfFrame,
  input  logic [10:0]       pixelX,
  input  logic [10:0]       pixelY,
  input  logic              playerDR,
  input  logic              brickDR,
  input  logic [10:0]       topLeftX,
  input  logic [10:0]       topLeftY,
  output logic              collision,
  output logic [3:0]        HitEdgeCode,
  output logic [CNT_W-1:0]  overlapCount
);

  localparam logic [CNT_W-1:0] MIN_HITS_C = CNT_W'(MIN_HITS);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  // ---------------- stage 1: register hit and sprite-relative offset -------
  logic hit_q;
  off_t offx_q;
  off_t offy_q;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      hit_q  <= 1'b0;
      offx_q <= '0;
      offy_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every register
      // samples the pre-edge values regardless of statement order.
      hit_q  <= playerDR & brickDR;
      offx_q <= off_t'({1'b0, pixelX}) - off_t'({topLeftX[10], topLeftX});
      offy_q <= off_t'({1'b0, pixelY}) - off_t'({topLeftY[10], topLeftY});
    end
  end

  // ---------------- stage 2: band classification ---------------------------
  edge_code_t band_mask;
  logic       band_valid;
  logic       hit_valid;

  edge_band_classifier #(
    .SPRITE_W (SPRITE_W),
    .SPRITE_H (SPRITE_H),
    .EDGE_W   (EDGE_W)
  ) u_classifier (
    .offx_i  (offx_q),
    .offy_i  (offy_q),
    .band_o  (band_mask),
    .valid_o (band_valid)
  );

  assign hit_valid = hit_q & band_valid;

  // ---------------- counters, border contact, snapshot value ---------------
  logic [CNT_W-1:0] edge_cnt_q   [4];
  logic [CNT_W-1:0] edge_cnt_inc [4];
  logic [CNT_W-1:0] total_q;
  logic [CNT_W-1:0] total_inc;
  edge_code_t       border;
  edge_code_t       snap_code;
  off_t             tlx_ext;
  off_t             tly_ext;

  assign tlx_ext = off_t'({topLeftX[10], topLeftX});
  assign tly_ext = off_t'({topLeftY[10], topLeftY});

  always_comb begin
    border    = '0;
    snap_code = '0;
    total_inc = hit_valid ? sat_inc(total_q) : total_q;
    for (int i = 0; i < 4; i++) begin
      edge_cnt_inc[i] = (hit_valid && band_mask[i]) ? sat_inc(edge_cnt_q[i])
                                                     : edge_cnt_q[i];
    end

    border[EDGE_LEFT]   = (tlx_ext <= off_t'(0));
    border[EDGE_RIGHT]  = ((tlx_ext + off_t'(SPRITE_W)) >= off_t'(SCREEN_W));
    border[EDGE_TOP]    = (tly_ext <= off_t'(0));
    border[EDGE_BOTTOM] = ((tly_ext + off_t'(SPRITE_H)) >= off_t'(SCREEN_H));

    for (int i = 0; i < 4; i++) begin
      snap_code[i] = (edge_cnt_q[i] >= MIN_HITS_C) | border[i];
    end
  end

  // ---------------- frame FSM with registered outputs ----------------------
  det_state_t       state_q;
  edge_code_t       hit_edge_q;
  logic [CNT_W-1:0] overlap_q;
  logic             collision_q;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q     <= ST_ACCUM;
      hit_edge_q  <= '0;
      overlap_q   <= '0;
      collision_q <= 1'b0;
      total_q     <= '0;
      // NOTE: the counter array is a handful of flops, not a RAM, so it is
      // reset like any other register.
      for (int i = 0; i < 4; i++) edge_cnt_q[i] <= '0;
    end else begin
      collision_q <= 1'b0;
      case (state_q)
        ST_ACCUM: begin
          // A hit landing on the startOfFrame cycle is still counted here,
          // so the snapshot next cycle sees it.
          total_q <= total_inc;
          for (int i = 0; i < 4; i++) edge_cnt_q[i] <= edge_cnt_inc[i];
          if (startOfFrame) state_q <= ST_SNAP;
        end
        ST_SNAP: begin
          // Counters restart for the new frame; the hit in flight is dropped.
          hit_edge_q <= snap_code;
          overlap_q  <= total_q;
          total_q    <= '0;
          for (int i = 0; i < 4; i++) edge_cnt_q[i] <= '0;
          state_q    <= ST_REPORT;
        end
        ST_REPORT: begin
          collision_q <= (hit_edge_q != '0);
          total_q     <= total_inc;
          for (int i = 0; i < 4; i++) edge_cnt_q[i] <= edge_cnt_inc[i];
          state_q     <= ST_ACCUM;
        end
        default: state_q <= ST_ACCUM;
      endcase
    end
  end

  assign collision    = collision_q;
  assign HitEdgeCode  = hit_edge_q;
  assign overlapCount = overlap_q;

endmodule

// File: tb/tb_player_edge_detector.sv
// ---------------------------------------------------------------------------
// tb_player_edge_detector
// Directed bench for player_edge_detector. Inputs change on the falling edge,
// outputs are checked on the falling edge; expected values are hand-computed.
// ---------------------------------------------------------------------------
module tb_player_edge_detector;

  logic        clk;
  logic        resetN;
  logic        startOfFrame;
  logic [10:0] pixelX;
  logic [10:0] pixelY;
  logic        playerDR;
  logic        brickDR;
  logic [10:0] topLeftX;
  logic [10:0] topLeftY;
  logic        collision;
  logic [3:0]  HitEdgeCode;
  logic [7:0]  overlapCount;

  int checks   = 0;
  int failures = 0;

  player_edge_detector dut (
    .clk          (clk),
    .resetN       (resetN),
    .startOfFrame (startOfFrame),
    .pixelX       (pixelX),
    .pixelY       (pixelY),
    .playerDR     (playerDR),
    .brickDR      (brickDR),
    .topLeftX     (topLeftX),
    .topLeftY     (topLeftY),
    .collision    (collision),
    .HitEdgeCode  (HitEdgeCode),
    .overlapCount (overlapCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One overlap pixel at sprite offset (ox,oy) relative to (100,100).
  task automatic hit(input int ox, input int oy);
    pixelX   = 11'(100 + ox);
    pixelY   = 11'(100 + oy);
    playerDR = 1'b1;
    brickDR  = 1'b1;
    @(negedge clk);
    playerDR = 1'b0;
    brickDR  = 1'b0;
  endtask

  task automatic idle(input int n);
    playerDR = 1'b0;
    brickDR  = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // Pulse startOfFrame and check the full report sequence.
  task automatic report(input string tag, input logic [3:0] exp_code,
                        input logic [7:0] exp_cnt, input logic exp_coll);
    startOfFrame = 1'b1;
    @(negedge clk);
    startOfFrame = 1'b0;
    check({tag, ".coll_sof+1"}, collision, 1'b0);
    @(negedge clk);
    check({tag, ".code"}, HitEdgeCode, exp_code);
    check({tag, ".count"}, overlapCount, exp_cnt);
    check({tag, ".coll_sof+2edge"}, collision, 1'b0);
    @(negedge clk);
    check({tag, ".coll_pulse"}, collision, exp_coll);
    @(negedge clk);
    check({tag, ".coll_after"}, collision, 1'b0);
    check({tag, ".code_held"}, HitEdgeCode, exp_code);
  endtask

  initial begin
    resetN       = 1'b0;
    startOfFrame = 1'b0;
    pixelX       = '0;
    pixelY       = '0;
    playerDR     = 1'b0;
    brickDR      = 1'b0;
    topLeftX     = 11'd100;
    topLeftY     = 11'd100;
    repeat (2) @(negedge clk);
    check("reset.collision", collision, 1'b0);
    check("reset.code", HitEdgeCode, 4'h0);
    check("reset.count", overlapCount, 8'd0);
    resetN = 1'b1;
    idle(2);

    // Bricks under the bottom two rows: 64 bottom-band hits.
    for (int y = 30; y < 32; y++)
      for (int x = 0; x < 32; x++) hit(x, y);
    // Sprite pixels without a brick are not overlaps.
    pixelX = 11'd110; pixelY = 11'd110; playerDR = 1'b1;
    @(negedge clk);
    idle(2);
    report("bottom_rows", 4'b0001, 8'd64, 1'b1);

    // Two left-band pixels: below MIN_HITS.
    hit(1, 10); hit(1, 11);
    idle(2);
    report("left_two", 4'b0000, 8'd2, 1'b0);

    // Corner pixel: bottom only, three frames in a row.
    for (int f = 0; f < 3; f++) begin
      hit(0, 31); hit(0, 31); hit(0, 31);
      idle(2);
      report("corner", 4'b0001, 8'd3, 1'b1);
    end

    // Overlaps just outside the sprite box are discarded.
    hit(32, 5); hit(32, 5); hit(32, 5);
    hit(10, -1); hit(10, -1); hit(10, -1);
    idle(2);
    report("outside", 4'b0000, 8'd0, 1'b0);

    // Right band plus top band in one frame.
    hit(30, 15); hit(30, 15); hit(30, 15);
    hit(10, 0); hit(10, 0); hit(10, 0);
    idle(2);
    report("right_top", 4'b0110, 8'd6, 1'b1);

    // Screen-border contact with no overlap.
    topLeftX = 11'd0;
    report("border_left0", 4'b1000, 8'd0, 1'b1);
    topLeftX = 11'h7FB; // -5
    report("border_leftneg", 4'b1000, 8'd0, 1'b1);
    topLeftX = 11'd608;
    report("border_right", 4'b0010, 8'd0, 1'b1);
    topLeftX = 11'd607;
    topLeftY = 11'd448;
    report("border_bottom", 4'b0001, 8'd0, 1'b1);
    topLeftY = 11'd447;
    report("no_border", 4'b0000, 8'd0, 1'b0);
    topLeftY = 11'd0;
    report("border_top", 4'b0100, 8'd0, 1'b1);
    topLeftX = 11'd100;
    topLeftY = 11'd100;

    // 300 bottom-band hits: counters saturate at 255.
    for (int i = 0; i < 300; i++) hit(i % 32, 28 + (i / 32) % 4);
    idle(2);
    report("saturate", 4'b0001, 8'd255, 1'b1);

    // Third left hit lands in stage 2 on the startOfFrame cycle and counts.
    hit(1, 10); hit(1, 10); hit(1, 10);
    report("same_cycle", 4'b1000, 8'd3, 1'b1);

    // Reset mid-frame after 10 hits; report covers post-reset hits only.
    for (int i = 0; i < 10; i++) hit(i, 30);
    #2 resetN = 1'b0;
    #1;
    check("midreset.code", HitEdgeCode, 4'h0);
    check("midreset.count", overlapCount, 8'd0);
    check("midreset.collision", collision, 1'b0);
    @(negedge clk);
    resetN = 1'b1;
    hit(0, 29); hit(1, 29); hit(2, 29); hit(3, 29);
    idle(2);
    report("post_reset", 4'b0001, 8'd4, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
